// File: rtl/rf_write_scheduler.sv
// Register-file write port scheduler: ALU writes first, long-latency
// results buffered in order, with WAW squash and a pending-write query.
module rf_write_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     lx_valid,
  output logic                     lx_ready,
  input  logic [AW-1:0]            lx_rd,
  input  logic [DW-1:0]            lx_data,
  output logic                     RegWrite,
  output logic [AW-1:0]            RDaddr,
  output logic [DW-1:0]            RDdata,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] rd_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         live_q, live_d;
  logic [PW-1:0]            rptr_q, rptr_d;
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [DW-1:0]            data_oq, data_od;

  logic alu_win, pop, push;

  assign alu_win  = alu_valid && (alu_rd != '0);
  assign pop      = !alu_win && (cnt_q != '0);
  assign lx_ready = (cnt_q < FULL);
  assign push     = lx_valid && lx_ready && (lx_rd != '0);

  always_comb begin
    chk_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] == chk_addr) && (chk_addr != '0))
        chk_busy = 1'b1;
    end
  end

  always_comb begin
    live_d  = live_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = '0;
    data_od = '0;
    if (alu_win) begin
      we_d    = 1'b1;
      addr_d  = alu_rd;
      data_od = alu_data;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == alu_rd)
          live_d[i] = 1'b0;
      end
    end else if (pop) begin
      if (live_q[rptr_q]) begin
        we_d    = 1'b1;
        addr_d  = rd_q[rptr_q];
        data_od = data_q[rptr_q];
      end
      live_d[rptr_q] = 1'b0;
      rptr_d = rptr_q + PW'(1);
    end
    // applied after the squash so a same-cycle push stays live
    if (push) begin
      live_d[wptr_q] = 1'b1;
      wptr_d = wptr_q + PW'(1);
    end
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CW'(1);
      pop && !push: cnt_d = cnt_q - CW'(1);
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      data_q  <= '0;
      live_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_oq <= '0;
    end else begin
      live_q  <= live_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_oq <= data_od;
      if (push) begin
        rd_q[wptr_q]   <= lx_rd;
        data_q[wptr_q] <= lx_data;
      end
    end
  end

  assign RegWrite   = we_q;
  assign RDaddr     = addr_q;
  assign RDdata     = data_oq;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios plus random traffic
// checked against a queue-based model of the write stream.
module tb_rf_write_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lx_valid;
  logic        lx_ready;
  logic [4:0]  lx_rd;
  logic [31:0] lx_data;
  logic        RegWrite;
  logic [4:0]  RDaddr;
  logic [31:0] RDdata;
  logic [4:0]  chk_addr;
  logic        chk_busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t q[$];

  rf_write_scheduler #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lx_valid(lx_valid), .lx_ready(lx_ready),
    .lx_rd(lx_rd), .lx_data(lx_data),
    .RegWrite(RegWrite), .RDaddr(RDaddr), .RDdata(RDdata),
    .chk_addr(chk_addr), .chk_busy(chk_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive at negedge, check combinational view, model, edge
  task automatic step(input logic v, input logic [4:0] ar,
                      input logic [31:0] ad, input logic lv,
                      input logic [4:0] lr, input logic [31:0] ld,
                      input logic [4:0] ca);
    bit rdy, busy, win, ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t h, e;
    alu_valid = v;  alu_rd = ar; alu_data = ad;
    lx_valid  = lv; lx_rd  = lr; lx_data  = ld;
    chk_addr  = ca;
    #1;
    rdy  = q.size() < DEPTH;
    busy = 1'b0;
    foreach (q[i])
      if (q[i].live && q[i].rd == ca && ca != 0) busy = 1'b1;
    chk("lx_ready", lx_ready, rdy);
    chk("chk_busy", chk_busy, busy);
    chk("fifo_count", fifo_count, q.size());
    win = v && ar != 0;
    ew = 1'b0; ea = '0; ed = '0;
    if (win) begin
      ew = 1'b1; ea = ar; ed = ad;
      foreach (q[i]) if (q[i].rd == ar) q[i].live = 1'b0;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      if (h.live) begin ew = 1'b1; ea = h.rd; ed = h.d; end
    end
    if (lv && rdy && lr != 0) begin
      e.rd = lr; e.d = ld; e.live = 1'b1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("RegWrite", RegWrite, ew);
    if (ew) begin
      chk("RDaddr", RDaddr, ea);
      chk("RDdata", RDdata, ed);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lx_valid = 0; lx_rd = 0; lx_data = 0; chk_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_RDaddr", RDaddr, 0);
    chk("rst_RDdata", RDdata, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single ALU write
    step(1, 5, 32'h1234, 0, 0, 0, 0);
    idle(1);

    // two buffered writes drain in order
    step(0, 0, 0, 1, 3, 32'hAA, 3);
    step(0, 0, 0, 1, 4, 32'hBB, 4);
    idle(2);
    chk("drain_count", fifo_count, 0);

    // ALU busy while FIFO fills past capacity
    for (int i = 0; i < 6; i++)
      step(1, 7, 32'h700 + i, i < 5, 5'(10 + i), 32'hC0 + i, 5'(10 + i));
    idle(5);

    // WAW squash of a buffered write
    step(1, 7, 32'h1, 1, 9, 32'h11, 9);
    step(1, 9, 32'h22, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 9);
    idle(1);

    // register 0 is never written
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
    chk("r0_count", fifo_count, 0);

    // reset mid-drain
    step(1, 6, 32'h60, 1, 11, 32'h1, 11);
    step(1, 6, 32'h61, 1, 12, 32'h2, 12);
    step(1, 6, 32'h62, 1, 13, 32'h3, 13);
    step(0, 0, 0, 0, 0, 0, 12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_RegWrite", RegWrite, 0);
    chk("mid_rst_RDaddr", RDaddr, 0);
    chk("mid_rst_RDdata", RDdata, 0);
    chk("mid_rst_count", fifo_count, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 99) < 60,
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    idle(6);
    chk("final_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Writer-side front end for the register file's single write port (RegWrite/RDaddr/RDdata).
- Merges two result sources into one registered write stream:
  - the fixed-timing ALU writeback, which can never stall;
  - the long-latency channel (mul/div/load), which uses a valid/ready handshake and is buffered in a small in-order FIFO.
- Suppresses writes to register 0, squashes stale buffered writes (WAW) and reports pending-write hazards to issue logic.

Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  AW  ALU destination register
- alu_data  input  DW  ALU result
- lx_valid  input  1  long-latency result offered
- lx_ready  output  1  FIFO can accept; a transfer occurs when lx_valid && lx_ready
- lx_rd  input  AW  long-latency destination register
- lx_data  input  DW  long-latency result
- RegWrite  output  1  register write enable to register file (registered)
- RDaddr  output  AW  write address (registered)
- RDdata  output  DW  write data (registered)
- chk_addr  input  AW  register queried by issue logic
- chk_busy  output  1  combinational: a live FIFO entry targets chk_addr
- fifo_count  output  clog2(DEPTH)+1  live plus squashed entries held

Behaviour:
- Reset (async, rst_n=0):
  - RegWrite=0, RDaddr=0, RDdata=0, fifo_count=0.
  - All entries invalid; read and write pointers = 0.
  - Reset asserted mid-operation drops all buffered writes; no write is issued on the cycle rst_n deasserts.
- Latency: a winning source is written to RegWrite/RDaddr/RDdata on the next rising edge. The outputs hold for exactly one cycle; RegWrite=0 otherwise.
- Per-cycle priority:
  1. alu_valid && alu_rd!=0: issue the ALU write. The FIFO is not popped.
  2. Else, FIFO non-empty: pop the head.
     - Live head: issue it.
     - Squashed head: discard it, RegWrite=0 that cycle.
  3. Else: RegWrite=0.
- alu_valid with alu_rd==0: no write. The FIFO may pop that cycle, since the ALU counts as idle.
- lx_ready = (fifo_count < DEPTH), using registered count only. No push when full, even if a pop occurs in the same cycle.
- Push:
  - Accepted entry stored with live=1 at the write pointer; pointer wraps modulo DEPTH.
  - Accepted with lx_rd==0: handshake completes, nothing stored, count unchanged.
- WAW squash: an issued ALU write to rd X clears live on every stored entry with rd==X in the same edge.
  - An lx entry pushed in that same cycle with rd==X is younger and stays live.
- Simultaneous push and pop: count unchanged; both pointers advance.
- chk_busy: OR over stored entries of (live && rd==chk_addr). Always 0 for chk_addr==0.
- Buffered writes leave the FIFO in order. No bypass of RDdata to the register file read ports.

Test Plan:
- Reset, then alu_valid, rd=5, data=0x1234 -> next cycle RegWrite=1, RDaddr=5, RDdata=0x1234; following cycle RegWrite=0.
- Push lx rd=3, d=0xAA and rd=4, d=0xBB with ALU idle -> writes (3,0xAA) then (4,0xBB) on consecutive cycles; fifo_count returns to 0.
- Hold alu_valid (rd=7) for 6 cycles while offering 5 lx pushes (DEPTH=4) -> 4 accepted, lx_ready=0 on the 5th; only ALU writes until ALU idles, then 4 FIFO writes in order.
- Buffer lx rd=9, d=0x11, then ALU rd=9, d=0x22 -> chk_busy(9) 1 then 0; writes: (9,0x22), then one cycle RegWrite=0 (squashed pop); final value 0x22.
- ALU rd=0 and lx rd=0 pushes -> no RegWrite ever; fifo_count stays 0.
- Three entries buffered, pulse rst_n low mid-drain -> outputs 0 immediately, fifo_count=0, no further writes after release.
